// File: rtl/cmult_result_buffer.sv
// -----------------------------------------------------------------------------
// cmult_result_buffer
//
// Output stage of the complex multiplier. The real product (p_r on p_r_ce) is
// parked in a hold register. The matching imaginary product (p_i on p_i_ce)
// completes the pair, and the pair is queued in a DEPTH-entry FIFO. The consumer
// drains the FIFO through a valid/ready handshake. space_ok tells the operand
// source whether one more complete job still fits. It counts both the queued
// entries and a half-finished pair held in the hold register.
//
// Optional feature (macro CMULT_RESULT_CNT_EN):
//   When the macro is defined, the block adds the output result_cnt[15:0]. It is
//   a wrapping count of pop handshakes. When the macro is undefined, the port
//   and the counter are both absent.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high, clears all state
//   p_r        in   real product, valid when p_r_ce=1
//   p_r_ce     in   real-part strobe
//   p_i        in   imaginary product, valid when p_i_ce=1
//   p_i_ce     in   imaginary-part strobe
//   out_valid  out  head entry available
//   out_ready  in   consumer accepts head entry
//   out_re     out  head real part
//   out_im     out  head imaginary part
//   space_ok   out  one more complete job fits
//   overflow   out  sticky, a pair was dropped on a full FIFO
//   proto_err  out  sticky, the strobe sequence was violated
//   result_cnt out  pop handshake count (only with CMULT_RESULT_CNT_EN)
// -----------------------------------------------------------------------------
module cmult_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] p_r,
  input  logic              p_r_ce,
  input  logic [DATA_W-1:0] p_i,
  input  logic              p_i_ce,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              space_ok,
  output logic              overflow,
  output logic              proto_err
`ifdef CMULT_RESULT_CNT_EN
  ,output logic [15:0]      result_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL     = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] C_DEPTH_X  = (AW+2)'(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

  // Storage and state
  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic [DATA_W-1:0]   r_hold;
  logic                r_pending;
  logic                r_out_valid;
  logic                r_space_ok;
  logic                r_overflow;
  logic                r_proto_err;

  // Next-state wires
  logic              w_push_req;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_proto_viol;
  logic              w_pending_next;
  logic [AW:0]       w_count_next;
  logic [AW+1:0]     w_occupancy;
  logic              w_space_ok_next;
  logic [2*DATA_W-1:0] w_head;

  // Handshake decode. A push sees the old pending flag, so a same-cycle
  // p_r_ce/p_i_ce pair closes the previous job before the new real part is held.
  always_comb begin
    w_push_req   = p_i_ce & r_pending;
    w_pop        = r_out_valid & out_ready;
    w_full       = (r_count == C_FULL);
    // A full FIFO still accepts the push when a pop frees a slot in the same cycle.
    w_push       = w_push_req & (~w_full | w_pop);
    w_drop       = w_push_req & w_full & ~w_pop;
    w_proto_viol = (p_i_ce & ~r_pending) | (p_r_ce & r_pending & ~p_i_ce);
    if (p_r_ce) begin
      w_pending_next = 1'b1;
    end else if (p_i_ce) begin
      w_pending_next = 1'b0;
    end else begin
      w_pending_next = r_pending;
    end
    w_count_next    = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    // A half-built pair reserves a slot, so an accepted job can always land.
    w_occupancy     = {1'b0, w_count_next} + {{(AW+1){1'b0}}, w_pending_next};
    w_space_ok_next = (w_occupancy < C_DEPTH_X);
  end

  // Pairing, FIFO pointers, occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= {AW{1'b0}};
      r_rptr      <= {AW{1'b0}};
      r_count     <= {(AW+1){1'b0}};
      r_hold      <= {DATA_W{1'b0}};
      r_pending   <= 1'b0;
      r_out_valid <= 1'b0;
      r_space_ok  <= 1'b1;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (p_r_ce) begin
        r_hold <= p_r;
      end else begin
        r_hold <= r_hold;
      end
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end else begin
        r_rptr <= r_rptr;
      end
      r_pending   <= w_pending_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != {(AW+1){1'b0}});
      r_space_ok  <= w_space_ok_next;
      r_overflow  <= r_overflow | w_drop;
      r_proto_err <= r_proto_err | w_proto_viol;
    end
  end

  // FIFO storage, cleared on reset so that no stale pair can surface
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {(2*DATA_W){1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {r_hold, p_i};
      end else begin
        r_mem[r_wptr] <= r_mem[r_wptr];
      end
    end
  end

  // Head selection. The outputs read zero while the FIFO is empty.
  always_comb begin
    if (r_out_valid) begin
      w_head = r_mem[r_rptr];
    end else begin
      w_head = {(2*DATA_W){1'b0}};
    end
  end

  assign out_valid = r_out_valid;
  assign out_re    = w_head[2*DATA_W-1:DATA_W];
  assign out_im    = w_head[DATA_W-1:0];
  assign space_ok  = r_space_ok;
  assign overflow  = r_overflow;
  assign proto_err = r_proto_err;

`ifdef CMULT_RESULT_CNT_EN
  logic [15:0] r_result_cnt;

  // Pop handshake counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_cnt <= 16'h0000;
    end else if (w_pop) begin
      r_result_cnt <= r_result_cnt + 16'h0001;
    end else begin
      r_result_cnt <= r_result_cnt;
    end
  end

  assign result_cnt = r_result_cnt;
`endif

endmodule

// File: tb/tb_cmult_result_buffer.sv
module tb_cmult_result_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] p_r;
  logic          p_r_ce;
  logic [DW-1:0] p_i;
  logic          p_i_ce;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          space_ok;
  logic          overflow;
  logic          proto_err;
`ifdef CMULT_RESULT_CNT_EN
  logic [15:0]   result_cnt;
`endif

  always #5 clk = ~clk;

  cmult_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p_r(p_r), .p_r_ce(p_r_ce), .p_i(p_i), .p_i_ce(p_i_ce),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .space_ok(space_ok), .overflow(overflow), .proto_err(proto_err)
`ifdef CMULT_RESULT_CNT_EN
    , .result_cnt(result_cnt)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  // Behavioural model of the buffer: a queue of pairs plus the half-built job
  logic [DW-1:0] m_re[$];
  logic [DW-1:0] m_im[$];
  logic [DW-1:0] m_hold = '0;
  logic          m_pend = 1'b0;
  logic          m_ovf  = 1'b0;
  logic          m_perr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Apply the rules for one clock edge, using the inputs that are currently driven
  task automatic model_update();
    bit pop, full;
    if (reset) begin
      m_re.delete(); m_im.delete();
      m_hold = '0; m_pend = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    end else begin
      pop  = (m_re.size() != 0) && out_ready;
      full = (m_re.size() == DEPTH);
      if (p_i_ce && !m_pend) m_perr = 1'b1;
      if (p_r_ce && m_pend && !p_i_ce) m_perr = 1'b1;
      if (pop) begin
        void'(m_re.pop_front());
        void'(m_im.pop_front());
      end
      if (p_i_ce && m_pend) begin
        if (!full || pop) begin
          m_re.push_back(m_hold);
          m_im.push_back(p_i);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (p_r_ce) begin
        m_hold = p_r; m_pend = 1'b1;
      end else if (p_i_ce) begin
        m_pend = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and return just after the negedge
  task automatic step(input logic rce, input logic [DW-1:0] r, input logic ice,
                      input logic [DW-1:0] i, input logic rdy, input logic rst);
    p_r_ce = rce; p_r = r; p_i_ce = ice; p_i = i; out_ready = rdy; reset = rst;
    model_update();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic job(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic rdy);
    step(1'b1, r, 1'b0, '0, rdy, 1'b0);
    step(1'b0, '0, 1'b1, i, rdy, 1'b0);
  endtask

  // Compare the DUT with the model on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_re.size() != 0));
      if (m_re.size() != 0) begin
        chk("out_re", 64'(out_re), 64'(m_re[0]));
        chk("out_im", 64'(out_im), 64'(m_im[0]));
      end
      chk("space_ok", 64'(space_ok), 64'((m_re.size() + int'(m_pend)) < DEPTH));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
    end
  end

  initial begin
    p_r = '0; p_r_ce = 1'b0; p_i = '0; p_i_ce = 1'b0; out_ready = 1'b0; reset = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_re", 64'(out_re), 64'd0);
    chk("rst_im", 64'(out_im), 64'd0);
    chk("rst_space", 64'(space_ok), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);

    // Single job: 1-cycle latency, immediate pop
    step(1'b1, 32'h0000_0005, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_re", 64'(out_re), 64'd5);
    chk("t1_im", 64'(out_im), 64'h0000_0000_FFFF_FFFD);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("t1_valid_after", 64'(out_valid), 64'd0);

    // Fill to DEPTH, then drain in order
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) job(32'(k), 32'(k * 10), 1'b0);
    chk("t2_space_full", 64'(space_ok), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("t2_order_re", 64'(out_re), 64'(k));
      chk("t2_order_im", 64'(out_im), 64'(k * 10));
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      if (k == 1) chk("t2_space_back", 64'(space_ok), 64'd1);
    end
    chk("t2_empty", 64'(out_valid), 64'd0);

    // Overflow, followed by a push and a pop in the same cycle while full
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) job(32'(k), 32'(k * 10), 1'b0);
    job(32'd5, 32'd50, 1'b0);
    chk("t3_overflow", 64'(overflow), 64'd1);
    step(1'b1, 32'd5, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'd50, 1'b1, 1'b0);
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);
    for (int k = 2; k <= 5; k++) begin
      chk("t3_drain_re", 64'(out_re), 64'(k));
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    end
    chk("t3_empty", 64'(out_valid), 64'd0);

    // Protocol errors
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'd2, 1'b0, 1'b0);
    chk("t4_lone_pi", 64'(proto_err), 64'd1);
    chk("t4_no_push", 64'(out_valid), 64'd0);
    step(1'b1, 32'd7, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'd9, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'd2, 1'b0, 1'b0);
    chk("t4_re", 64'(out_re), 64'd9);
    chk("t4_im", 64'(out_im), 64'd2);
    chk("t4_perr", 64'(proto_err), 64'd1);

    // Reset in the middle of a job
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    job(32'd11, 32'd12, 1'b0);
    job(32'd13, 32'd14, 1'b0);
    step(1'b1, 32'd15, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_space", 64'(space_ok), 64'd1);
    chk("t5_perr_clr", 64'(proto_err), 64'd0);
    step(1'b0, '0, 1'b1, 32'd16, 1'b0, 1'b0);
    chk("t5_perr", 64'(proto_err), 64'd1);
    chk("t5_no_push", 64'(out_valid), 64'd0);

`ifdef CMULT_RESULT_CNT_EN
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) job(32'(k), 32'(k), 1'b0);
    for (int k = 1; k <= 3; k++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("cnt_three", 64'(result_cnt), 64'd3);
    job(32'd1, 32'd1, 1'b0);
    force dut.r_result_cnt = 16'hFFFF;
    #1;
    release dut.r_result_cnt;
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("cnt_wrap", 64'(result_cnt), 64'd0);
`endif

    // Randomized traffic
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cmult_result_buffer.md
Name: cmult_result_buffer

Overview:
- Output stage downstream of the complex-multiplier datapath and its step controller.
- Captures the real product on p_r_ce and the imaginary product on p_i_ce, pairs them, and queues each pair in a small FIFO.
- Presents pairs to the consumer with a valid/ready handshake.
- Drives space_ok back upstream so the operand source gates input_rdy and never starts a job the buffer cannot hold.

Parameters:
- DATA_W, 32, width of each product component (two's complement)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- p_r  in  DATA_W  real product from datapath; valid in the cycle p_r_ce=1
- p_r_ce  in  1  real-part strobe from controller
- p_i  in  DATA_W  imaginary product from datapath; valid in the cycle p_i_ce=1
- p_i_ce  in  1  imaginary-part strobe from controller
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_re  out  DATA_W  head real part
- out_im  out  DATA_W  head imaginary part
- space_ok  out  1  buffer can absorb one more complete job
- overflow  out  1  sticky: a pair was dropped because the FIFO was full
- proto_err  out  1  sticky: strobe sequence violated

Behaviour:
- Reset (synchronous, active-high, all state):
  - count=0, pointers=0, pending=0, hold register=0.
  - out_valid=0, out_re=out_im=0, space_ok=1, overflow=0, proto_err=0.
  - Reset asserted mid-job discards the held real part and all queued entries. The next p_i_ce without a preceding p_r_ce sets proto_err.
- Pairing:
  - p_r_ce=1: p_r is stored in the hold register and pending=1.
  - p_i_ce=1 with pending=1: push {hold, p_i} and clear pending.
  - p_i_ce=1 with pending=0: no push, proto_err<=1.
  - p_r_ce=1 with pending=1: hold is overwritten, pending stays 1, proto_err<=1.
  - p_r_ce and p_i_ce in the same cycle: push {hold(old), p_i} if pending, else set proto_err. The new p_r is then held and pending=1.
- Push:
  - Occurs in the p_i_ce cycle. The entry is visible at out_valid/out_re/out_im the next cycle when the FIFO was empty, so latency is 1 cycle.
- Pop:
  - Occurs when out_valid && out_ready.
  - The head advances at the clock edge; the next entry appears the following cycle.
  - out_re/out_im stay stable while out_valid && !out_ready.
  - out_ready while empty is ignored.
- Full:
  - Push with count==DEPTH and no pop in that cycle: the pair is dropped, overflow<=1, and count is unchanged.
  - Push and pop in the same cycle when full: both are accepted and count stays DEPTH.
- Empty:
  - Push and pop cannot coincide on the same entry. A push into an empty FIFO raises out_valid next cycle, with no combinational bypass.
- Pointers:
  - log2(DEPTH)-bit read and write pointers wrap modulo DEPTH.
  - count is a (log2(DEPTH)+1)-bit register.
- space_ok:
  - Registered; equals (count_next + pending_next) < DEPTH.
  - The controller issues one job at a time, so space_ok=1 at job acceptance guarantees the later push succeeds.
- Data is passed through unmodified: no rounding, no sign manipulation.
- overflow and proto_err clear only on reset.

Optional Feature:
- Macro: CMULT_RESULT_CNT_EN.
- Defined:
  - Adds output port result_cnt [15:0], reset to 0.
  - Increments on every pop handshake and wraps 0xFFFF->0x0000.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then p_r_ce with p_r=0x0000_0005; two cycles later p_i_ce with p_i=0xFFFF_FFFD, out_ready=1 -> out_valid=1 one cycle after p_i_ce with out_re=5, out_im=-3; out_valid=0 the cycle after; space_ok=1 throughout.
- out_ready=0, push 4 jobs (re=1..4, im=10..40) -> space_ok falls to 0 when count reaches 4. Then release out_ready -> entries pop in order (1,10),(2,20),(3,30),(4,40) and space_ok returns to 1 after the first pop.
- FIFO full with out_ready=0, then a fifth job -> pair dropped, overflow=1 and sticky, count stays 4. Repeat the fifth job with out_ready=1 in the push cycle -> accepted, count stays 4, no new drop.
- p_i_ce with no prior p_r_ce -> no push, proto_err=1. Two p_r_ce (7 then 9) then p_i_ce with p_i=2 -> entry (9,2), proto_err stays 1.
- Reset asserted between p_r_ce and p_i_ce with 2 entries queued -> out_valid=0, count=0, pending cleared, space_ok=1. The following lone p_i_ce sets proto_err.
- With CMULT_RESULT_CNT_EN defined, 3 pops -> result_cnt=3. Preload the counter to 0xFFFF via forced stimulus, then one pop -> result_cnt=0.
